calc1_port_arbiter: RTL

Front-end scheduler that shares a single add/sub/shift ALU between the four calc1 requester ports. Captures each port's two-cycle request (command + operand 1, then operand 2), arbitrates round-robin among pending ports, issues one operation at a time to the ALU, and routes the ALU response back to the originating port as a one-cycle response pulse. Sits between the external request/response pins and the shared ALU inside calc1.

---
 rtl/calc1_port_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/calc1_port_arbiter.sv
// Round-robin front end that lets four calc1 requester ports share one ALU:
// captures two-cycle requests, issues one op at a time, and routes responses back.
module calc1_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic        alu_valid,
    output logic [0:3]  alu_cmd,
    output logic [0:31] alu_op1,
    output logic [0:31] alu_op2,
    input  logic        alu_done,
    input  logic [0:1]  alu_resp,
    input  logic [0:31] alu_result
);

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_OP2  = 2'd1,
        P_PEND = 2'd2
    } port_state_t;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_BUSY = 1'b1
    } arb_state_t;

    logic [0:3]  cmd_in   [4];
    logic [0:31] data_in  [4];
    port_state_t port_state     [4];
    port_state_t port_state_nxt [4];
    logic [0:3]  port_cmd [4];
    logic [0:31] port_op1 [4];
    logic [0:31] port_op2 [4];
    logic [0:1]  resp_q   [4];
    logic [0:31] data_q   [4];

    arb_state_t  arb_state;
    arb_state_t  arb_state_nxt;
    logic [1:0]  rr_ptr;
    logic [1:0]  owner;
    logic [7:0]  tmo_cnt;

    logic        pend_found;
    logic [1:0]  grant_idx;
    logic [1:0]  scan_idx;
    logic        grant;
    logic        issue;
    logic        resp_valid;
    logic [1:0]  resp_port;
    logic [0:1]  resp_code;
    logic [0:31] resp_data;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data1 = data_q[0];
    assign out_data2 = data_q[1];
    assign out_data3 = data_q[2];
    assign out_data4 = data_q[3];

    function automatic logic cmd_is_valid(input logic [0:3] cmd);
        return (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
    endfunction

    // First pending port at or after rr_ptr, wrapping 4 -> 1.
    always_comb begin
        pend_found = 1'b0;
        grant_idx  = rr_ptr;
        scan_idx   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!pend_found && port_state[scan_idx] == P_PEND) begin
                pend_found = 1'b1;
                grant_idx  = scan_idx;
            end
        end
    end

    assign grant = (arb_state == A_IDLE) && pend_found;

    always_comb begin
        arb_state_nxt = arb_state;
        issue         = 1'b0;
        resp_valid    = 1'b0;
        resp_port     = owner;
        resp_code     = 2'd0;
        resp_data     = '0;
        case (arb_state)
            A_IDLE: begin
                if (pend_found) begin
                    if (cmd_is_valid(port_cmd[grant_idx])) begin
                        issue         = 1'b1;
                        arb_state_nxt = A_BUSY;
                    end else begin
                        resp_valid = 1'b1;
                        resp_port  = grant_idx;
                        resp_code  = 2'd2;
                    end
                end
            end
            A_BUSY: begin
                // A completion on the same edge as the timeout still wins.
                if (alu_done) begin
                    resp_valid    = 1'b1;
                    resp_code     = alu_resp;
                    resp_data     = alu_result;
                    arb_state_nxt = A_IDLE;
                end else if (tmo_cnt == 8'(TIMEOUT_CYCLES)) begin
                    resp_valid    = 1'b1;
                    resp_code     = 2'd3;
                    arb_state_nxt = A_IDLE;
                end
            end
            default: arb_state_nxt = A_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            port_state_nxt[i] = port_state[i];
            case (port_state[i])
                P_IDLE:  if (cmd_in[i] != 4'd0) port_state_nxt[i] = P_OP2;
                P_OP2:   port_state_nxt[i] = P_PEND;
                P_PEND:  if (resp_valid && resp_port == 2'(i)) port_state_nxt[i] = P_IDLE;
                default: port_state_nxt[i] = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_state <= A_IDLE;
            rr_ptr    <= 2'd0;
            owner     <= 2'd0;
            tmo_cnt   <= 8'd0;
            alu_valid <= 1'b0;
            alu_cmd   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
        end else begin
            arb_state <= arb_state_nxt;
            alu_valid <= issue;
            if (grant) begin
                rr_ptr <= grant_idx + 2'd1;
                owner  <= grant_idx;
            end
            // tmo_cnt equals the number of edges elapsed since the issue edge.
            if (issue) begin
                alu_cmd <= port_cmd[grant_idx];
                alu_op1 <= port_op1[grant_idx];
                alu_op2 <= port_op2[grant_idx];
                tmo_cnt <= 8'd1;
            end else if (resp_valid) begin
                tmo_cnt <= 8'd0;
            end else if (arb_state == A_BUSY) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                port_state[i] <= P_IDLE;
                port_cmd[i]   <= '0;
                port_op1[i]   <= '0;
                port_op2[i]   <= '0;
                resp_q[i]     <= '0;
                data_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                port_state[i] <= port_state_nxt[i];
                if (port_state[i] == P_IDLE && cmd_in[i] != 4'd0) begin
                    port_cmd[i] <= cmd_in[i];
                    port_op1[i] <= data_in[i];
                end
                if (port_state[i] == P_OP2) begin
                    port_op2[i] <= data_in[i];
                end
                if (resp_valid && resp_port == 2'(i)) begin
                    resp_q[i] <= resp_code;
                    data_q[i] <= resp_data;
                end else begin
                    resp_q[i] <= '0;
                    data_q[i] <= '0;
                end
            end
        end
    end

endmodule
